// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, default timing and command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StTx,
    StAck,
    StRelease,
    StAbort
  } ps2_tx_state_e;

  // Defaults assume a 50 MHz system clock.
  localparam int unsigned InhibitCyclesDef = 6000;
  localparam int unsigned StartTimeoutDef  = 750000;
  localparam int unsigned XferTimeoutDef   = 100000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Falling-edge index at which the device ACK is sampled.
  localparam logic [3:0] AckEdge = 4'd11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line with a falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Idle level of an open-drain PS/2 line is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_in};
      prev_q <= sync_q[1];
    end
  end

  assign line_sync = sync_q[1];
  assign fall      = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with request-to-send and ACK check.
// Define PS2_TX_RETRY_EN to retry once after a NACK or timeout before reporting an error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = InhibitCyclesDef,
  parameter int unsigned START_TIMEOUT  = StartTimeoutDef,
  parameter int unsigned XFER_TIMEOUT   = XferTimeoutDef
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] send_command,
  input  logic       send_en,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timeout,
  output logic       error_nack
);

  localparam int unsigned CntMax = max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] InhLast   = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] StartLast = CntW'(START_TIMEOUT - 1);
  localparam logic [CntW-1:0] XferLast  = CntW'(XFER_TIMEOUT - 1);

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall;
  logic unused_dat_fall;

  ps2_line_sync u_clk_sync (
    .clk       (CLOCK_50),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk       (CLOCK_50),
    .reset     (reset),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync),
    .fall      (dat_fall)
  );

  assign unused_dat_fall = dat_fall;

  ps2_tx_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            ack_q, ack_d;
  logic            busy_q;
  logic            sent_q, sent_d;
  logic            to_q, to_d;
  logic            nack_q, nack_d;
  logic            fail, fail_nack;
  logic            tx_dat_oe;
  logic [2:0]      bit_idx;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
  logic            hold_q, hold_d;
`endif

  // Edges 1..8 carry data LSB first; wraps 8 -> index 7.
  assign bit_idx = bit_q[2:0] - 3'd1;

  always_comb begin
    tx_dat_oe = 1'b0;
    if (bit_q >= 4'd1 && bit_q <= 4'd8) begin
      tx_dat_oe = ~data_q[bit_idx];
    end else if (bit_q == 4'd9) begin
      tx_dat_oe = ~par_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_d      = par_q;
    ack_d      = ack_q;
    sent_d     = 1'b0;
    to_d       = 1'b0;
    nack_d     = 1'b0;
    fail       = 1'b0;
    fail_nack  = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
    hold_d     = hold_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (send_en) begin
          data_d  = send_command;
          par_d   = odd_parity(send_command);
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
          hold_d  = 1'b0;
`endif
        end
      end
      StInhibit: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == InhLast) begin
          ps2_dat_oe = 1'b1;
          cnt_d      = '0;
          state_d    = StReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        ps2_dat_oe = 1'b1;
        if (clk_fall) begin
          bit_d   = 4'd1;
          cnt_d   = '0;
          state_d = StTx;
        end else if (cnt_q == StartLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTx: begin
        ps2_dat_oe = tx_dat_oe;
        if (cnt_q == XferLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            if (bit_q == AckEdge - 4'd1) begin
              bit_d   = AckEdge;
              ack_d   = dat_sync;
              state_d = StAck;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      StAck: begin
        if (!ack_q) begin
          state_d = StRelease;
        end else begin
          fail      = 1'b1;
          fail_nack = 1'b1;
        end
      end
      StRelease: begin
        if (clk_sync && dat_sync) begin
          sent_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StAbort: begin
`ifdef PS2_TX_RETRY_EN
        // A held abort keeps the lines released before the second attempt.
        if (hold_q) begin
          if (cnt_q == InhLast) begin
            hold_d  = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = StInhibit;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      state_d = StAbort;
      cnt_d   = '0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        hold_d  = 1'b1;
      end else begin
        to_d   = ~fail_nack;
        nack_d = fail_nack;
      end
`else
      to_d   = ~fail_nack;
      nack_d = fail_nack;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ack_q   <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      to_q    <= 1'b0;
      nack_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q <= 1'b0;
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != StIdle);
      sent_q  <= sent_d;
      to_q    <= to_d;
      nack_q  <= nack_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
      hold_q  <= hold_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign command_was_sent = sent_q;
  assign error_timeout    = to_q;
  assign error_nack       = nack_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard using the PS/2 request-to-send sequence, then checks the device ACK. It shares PS2_CLK/PS2_DAT with the existing PS/2 receive path. The top level drives each line as open-drain: line = oe ? 0 : Z.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles the host holds clock low (120 us).
START_TIMEOUT, 750000, max cycles from clock release to first device falling edge (15 ms).
XFER_TIMEOUT, 100000, max cycles from first falling edge to ACK edge (2 ms).

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-low reset.
send_command  in  8  byte to transmit; sampled on accepted send_en.
send_en  in  1  one-cycle request; accepted only when busy=0.
ps2_clk_in  in  1  raw PS2_CLK pin level.
ps2_dat_in  in  1  raw PS2_DAT pin level.
ps2_clk_oe  out  1  1 = pull PS2_CLK low.
ps2_dat_oe  out  1  1 = pull PS2_DAT low.
busy  out  1  high from accept until return to IDLE.
command_was_sent  out  1  one-cycle pulse: ACK received and lines released.
error_timeout  out  1  one-cycle pulse on timeout abort.
error_nack  out  1  one-cycle pulse: device left DAT high at ACK.

Behaviour:
- Reset (reset=0 at a CLOCK_50 edge): state IDLE, both oe=0, busy=0, all pulses 0, counters cleared. Reset mid-transfer releases both lines on the next edge.
- ps2_clk_in and ps2_dat_in pass through a 2-flop synchroniser. A falling edge is synced previous=1, current=0. Edge detection adds 2-3 cycles of latency, which is acceptable at a 10-16.7 kHz PS/2 clock.
- IDLE: on send_en=1, latch byte, compute parity = ~^byte (odd parity), busy=1, go to INHIBIT. send_en while busy is ignored.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES. In the final cycle, dat_oe=1 (start bit 0). Then go to REQ.
- REQ: clk_oe=0, dat_oe=1. Count to START_TIMEOUT; on expiry go to ABORT with error_timeout. On the 1st falling edge, go to TX.
- TX: the bit index advances on each falling edge.
  - Falling edges 1-8: dat_oe = ~data[k-1], LSB first.
  - Falling edge 9: dat_oe = ~parity.
  - Falling edge 10: dat_oe=0 (stop bit, line released high).
  - Falling edge 11: go to ACK check.
- ACK check: sample synced DAT at the 11th falling edge.
  - DAT=0: go to RELEASE.
  - DAT=1: error_nack, go to ABORT.
- XFER_TIMEOUT counts from the 1st falling edge through the 11th. On expiry go to ABORT with error_timeout.
- RELEASE: wait until synced CLK=1 and DAT=1, then pulse command_was_sent and go to IDLE (busy=0 in the same cycle as the pulse).
- ABORT: both oe=0, pulse the pending error, go to IDLE.
- A new request is accepted one cycle after return to IDLE.
- Counters are $clog2 of the largest parameter + 1 bits wide.
- The bit counter is 4 bits and saturates at 11; it never wraps.

Optional Feature:
Macro PS2_TX_RETRY_EN.
- Defined: a NACK or timeout on the first attempt does not raise an error. The block releases the lines for INHIBIT_CYCLES, then restarts from INHIBIT with the latched byte, busy held high. An error pulse fires only on the second failure. A retry_count[0] flag is kept internally.
- Undefined: the first failure pulses its error and returns to IDLE.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, REQ, TX, ACK, RELEASE, ABORT), default timing constants, command byte constants (CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA).
- One sub-module, ps2_line_sync: 2-flop synchroniser plus falling-edge strobe, instanced once per line. The receiver can reuse it.

Test Plan:
- send 0xED with device BFM (12.5 kHz clock, ACK) -> clk_oe high 6000 cycles; DAT sampled on device rising edges = 0,1,0,1,1,0,1,1,1, parity 1, stop 1; command_was_sent pulse once; busy low.
- send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; command_was_sent pulse once.
- No device clock after REQ -> error_timeout exactly START_TIMEOUT cycles after clk_oe falls; both oe=0.
- BFM leaves DAT high at 11th edge -> error_nack pulse, no command_was_sent (retry occurs instead if PS2_TX_RETRY_EN is defined).
- reset=0 at 5th falling edge -> next cycle clk_oe=dat_oe=0, busy=0; a subsequent send 0xFF completes normally.
- send_en pulsed while busy with 0x00 -> ignored; original byte transmitted unchanged.
